// File: rtl/ins_loader_pkg.sv
// ins_loader_pkg
// Shared parameters and types for the instruction loader and its byte packer.
// Optional feature macro: INS_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte and the CSUM state that checks it.
package ins_loader_pkg;

  // Opcode field width of an instruction word (opcode sits in the LSBs).
  localparam int OPCODE_WIDTH       = 3;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 3'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 3'd1;

  // Number of whole bytes needed to carry a word of the given bit width.
  function automatic int bytes_for_width(input int width);
    return (width + 7) / 8;
  endfunction

  // Bytes per instruction for the default operand width.
  localparam int INS_BYTES = bytes_for_width(OPCODE_WIDTH + 3 * DEFAULT_ADDR_WIDTH);

  // Loader state type, encoded as plain constants for compatibility with the
  // older tooling that reads this codebase.
  typedef logic [2:0] loader_state_t;

  localparam loader_state_t ST_HDR0 = 3'd0;
  localparam loader_state_t ST_HDR1 = 3'd1;
  localparam loader_state_t ST_BODY = 3'd2;
  localparam loader_state_t ST_RUN  = 3'd3;
`ifdef INS_LOADER_CHECKSUM_EN
  localparam loader_state_t ST_CSUM = 3'd4;
`endif

endpackage

// File: rtl/ins_loader_packer.sv
// ins_packer
// Collects a little-endian byte stream into instruction words. The first byte
// of an instruction lands in the LSBs; bits of the final byte that lie beyond
// the word width are dropped. word/word_done are valid in the same cycle the
// last byte of an instruction is presented, so the caller can register them.
// Assumes the word is wider than one byte.
module ins_packer
  import ins_loader_pkg::*;
#(
  parameter int WORD_WIDTH = OPCODE_WIDTH + 3 * DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_done
);

  localparam int NBYTES    = bytes_for_width(WORD_WIDTH);
  localparam int SR_WIDTH  = (NBYTES - 1) * 8;
  localparam int LAST_BITS = WORD_WIDTH - SR_WIDTH;
  localparam int IDX_WIDTH = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [SR_WIDTH-1:0]  shreg;
  logic [IDX_WIDTH-1:0] byte_idx;

  assign word_done = byte_valid && (byte_idx == IDX_WIDTH'(NBYTES - 1));
  assign word      = {byte_data[LAST_BITS-1:0], shreg};

  // Shift earlier bytes of the instruction down and count position within it.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (byte_valid) begin
      shreg    <= SR_WIDTH'({byte_data, shreg} >> 8);
      byte_idx <= word_done ? '0 : byte_idx + IDX_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ins_loader.sv
// ins_loader
// Loads a program from a host byte stream into instruction memory, holding the
// processor in reset while loading. Stream: count[7:0], count[15:8], then
// count instructions of INS_BYTES little-endian bytes each.
// Optional feature macro: INS_LOADER_CHECKSUM_EN -- expect one extra byte that
// is the XOR of every header and body byte; a mismatch flags err.
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 load_req,
  input  logic [7:0]                           s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic                                 ins_we,
  output logic [INS_ADDR_WIDTH-1:0]            ins_waddr,
  output logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0] ins_wdata,
  output logic                                 proc_rstn,
  output logic                                 load_done,
  output logic                                 err
);

  localparam int          WORD_WIDTH = OPCODE_WIDTH + 3 * ADDR_WIDTH;
  localparam logic [32:0] ADDR_LIMIT = 33'd1 << INS_ADDR_WIDTH;

  // Where a load goes once the header/body is fully consumed without error.
`ifdef INS_LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_BODY = ST_CSUM;
`else
  localparam loader_state_t AFTER_BODY = ST_RUN;
`endif

  loader_state_t         state;
  loader_state_t         state_nxt;
  logic [15:0]           count;
  logic [15:0]           ins_idx;
  logic [15:0]           hdr_count;
  logic                  accept;
  logic                  body_byte;
  logic                  word_done;
  logic                  last_ins;
  logic                  overflow_hdr;
  logic                  overflow_cnt;
  logic                  ins_in_range;
  logic [WORD_WIDTH-1:0] word;
`ifdef INS_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
  logic                  csum_ok;
`endif

  // A load request wins over a byte offered in the same cycle: the byte is
  // taken off the bus but thrown away.
  assign s_ready   = rstn && (state != ST_RUN);
  assign accept    = s_valid && s_ready && !load_req;
  assign body_byte = accept && (state == ST_BODY);

  // Full instruction count as it will be once the HDR1 byte lands.
  assign hdr_count    = {s_data, count[7:0]};
  assign overflow_hdr = {17'd0, hdr_count} > ADDR_LIMIT;
  assign overflow_cnt = {17'd0, count} > ADDR_LIMIT;
  assign last_ins     = ({1'b0, ins_idx} + 17'd1) == {1'b0, count};
  assign ins_in_range = {17'd0, ins_idx} < ADDR_LIMIT;

  ins_packer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (load_req),
    .byte_valid (body_byte),
    .byte_data  (s_data),
    .word       (word),
    .word_done  (word_done)
  );

`ifdef INS_LOADER_CHECKSUM_EN
  assign csum_ok = (s_data == csum);
`endif

  // Next-state selection; every transition is driven by an accepted byte or a
  // load request.
  always_comb begin
    state_nxt = state;
    if (load_req) begin
      state_nxt = ST_HDR0;
    end else if (accept) begin
      case (state)
        ST_HDR0: state_nxt = ST_HDR1;
        ST_HDR1: state_nxt = (hdr_count == 16'd0) ? AFTER_BODY : ST_BODY;
        ST_BODY: begin
          if (word_done && last_ins) begin
            state_nxt = overflow_cnt ? ST_HDR0 : AFTER_BODY;
          end
        end
`ifdef INS_LOADER_CHECKSUM_EN
        ST_CSUM: state_nxt = csum_ok ? ST_RUN : ST_HDR0;
`endif
        default: state_nxt = ST_HDR0;
      endcase
    end
  end

  // State register plus the processor reset and completion pulse, both
  // registered from the state being entered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_HDR0;
      proc_rstn <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      proc_rstn <= (state_nxt == ST_RUN);
      load_done <= (state_nxt == ST_RUN) && (state != ST_RUN);
    end
  end

  // Instruction count capture, instruction index and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rstn || load_req) begin
      count   <= '0;
      ins_idx <= '0;
      err     <= 1'b0;
    end else if (accept) begin
      case (state)
        ST_HDR0: count <= {8'd0, s_data};
        ST_HDR1: begin
          count[15:8] <= s_data;
          ins_idx     <= '0;
          if (overflow_hdr) begin
            err <= 1'b1;
          end
        end
        ST_BODY: begin
          if (word_done) begin
            ins_idx <= ins_idx + 16'd1;
          end
        end
`ifdef INS_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (!csum_ok) begin
            err <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Instruction-memory write port: one write the cycle after an instruction's
  // last byte, skipped for indices past the end of memory rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ins_we    <= 1'b0;
      ins_waddr <= '0;
      ins_wdata <= '0;
    end else begin
      ins_we <= word_done && ins_in_range;
      if (word_done && ins_in_range) begin
        ins_waddr <= INS_ADDR_WIDTH'(ins_idx);
        ins_wdata <= word;
      end
    end
  end

`ifdef INS_LOADER_CHECKSUM_EN
  // Running XOR of the header and body bytes of the current load.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      csum <= '0;
    end else if (accept) begin
      case (state)
        ST_HDR0: csum <= s_data;
        ST_HDR1, ST_BODY: csum <= csum ^ s_data;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ins_loader.sv
// tb_ins_loader
// Self-checking bench for ins_loader. A stream-level model (bytes accepted in
// the current load, counted with plain arithmetic) predicts every output each
// cycle; directed scenarios add hand-computed literal expectations.
// Honours INS_LOADER_CHECKSUM_EN when defined.
module tb_ins_loader;

  localparam int IAW   = 10;
  localparam int AW    = 10;
  localparam int OPW   = 3;
  localparam int WW    = OPW + 3 * AW;
  localparam int NB    = 5;
  localparam int LIMIT = 1 << IAW;
`ifdef INS_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           load_req = 1'b0;
  logic           s_valid = 1'b0;
  logic [7:0]     s_data = 8'd0;
  logic           s_ready;
  logic           ins_we;
  logic [IAW-1:0] ins_waddr;
  logic [WW-1:0]  ins_wdata;
  logic           proc_rstn;
  logic           load_done;
  logic           err;

  ins_loader #(
    .INS_ADDR_WIDTH (IAW),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .load_req  (load_req),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .ins_we    (ins_we),
    .ins_waddr (ins_waddr),
    .ins_wdata (ins_wdata),
    .proc_rstn (proc_rstn),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]        cur[$];
  bit                running = 1'b0;
  bit                m_err = 1'b0;
  bit                m_we = 1'b0;
  bit                m_done = 1'b0;
  int                m_waddr = 0;
  logic [WW-1:0]     m_wdata = '0;
  logic [IAW+WW-1:0] wr_log[$];
  int                done_count = 0;

  function automatic logic [7:0] xor_of_first(input int m);
    logic [7:0] x = 8'd0;
    for (int i = 0; i < m; i++) x ^= cur[i];
    return x;
  endfunction

  task automatic model_step(input bit r, input bit lr, input bit v, input logic [7:0] d);
    int len, n, body, total;
    logic [39:0] w;
    m_we   = 1'b0;
    m_done = 1'b0;
    if (!r || lr) begin
      cur.delete();
      running = 1'b0;
      m_err   = 1'b0;
    end else if (v && !running) begin
      cur.push_back(d);
      len = cur.size();
      if (len >= 2) begin
        n = int'(cur[0]) + 256 * int'(cur[1]);
        if (len == 2 && n > LIMIT) m_err = 1'b1;
        body = len - 2;
        if (body > 0 && body % NB == 0 && (body / NB - 1) < LIMIT) begin
          w = '0;
          for (int k = 0; k < NB; k++) w |= 40'(cur[len - NB + k]) << (8 * k);
          m_we    = 1'b1;
          m_waddr = body / NB - 1;
          m_wdata = w[WW-1:0];
        end
        total = 2 + NB * n + ((n > LIMIT) ? 0 : CS);
        if (len == total) begin
          if (n > LIMIT) begin
            cur.delete();
          end else if (CS == 1 && xor_of_first(len - 1) != cur[len-1]) begin
            m_err = 1'b1;
            cur.delete();
          end else begin
            running = 1'b1;
            m_done  = 1'b1;
          end
        end
      end
    end
  endtask

  // Compare process: step the model on each edge, check outputs 1 time unit later.
  initial begin
    bit r_i, lr_i, v_i;
    logic [7:0] d_i;
    forever begin
      @(posedge clk);
      r_i  = rstn;
      lr_i = load_req;
      v_i  = s_valid;
      d_i  = s_data;
      model_step(r_i, lr_i, v_i, d_i);
      #1;
      check_output("s_ready", 64'(s_ready), 64'(r_i && !running));
      check_output("ins_we", 64'(ins_we), 64'(m_we));
      check_output("load_done", 64'(load_done), 64'(m_done));
      check_output("proc_rstn", 64'(proc_rstn), 64'(running));
      check_output("err", 64'(err), 64'(m_err));
      if (m_we) begin
        check_output("ins_waddr", 64'(ins_waddr), 64'(m_waddr));
        check_output("ins_wdata", 64'(ins_wdata), 64'(m_wdata));
      end
      if (ins_we) wr_log.push_back({ins_waddr, ins_wdata});
      if (load_done) done_count++;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pkt[$];
  int         pkt_n = 0;

  task automatic idle(input int n);
    repeat (n) begin
      s_valid  = 1'b0;
      load_req = 1'b0;
      s_data   = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    s_valid  = 1'b1;
    load_req = 1'b0;
    s_data   = b;
    @(negedge clk);
    s_valid  = 1'b0;
  endtask

  task automatic pulse_load_req(input bit with_byte);
    load_req = 1'b1;
    s_valid  = with_byte;
    s_data   = 8'($urandom);
    @(negedge clk);
    load_req = 1'b0;
    s_valid  = 1'b0;
  endtask

  task automatic pkt_start(input int n);
    pkt.delete();
    pkt_n = n;
    pkt.push_back(8'(n));
    pkt.push_back(8'(n >> 8));
  endtask

  task automatic pkt_add_word(input logic [WW-1:0] w, input bit junk);
    logic [39:0] full;
    full = 40'(w);
    if (junk) full[39:WW] = 7'($urandom);
    for (int k = 0; k < NB; k++) pkt.push_back(full[8*k +: 8]);
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[WW-1:0];
  endfunction

  task automatic pkt_send(input bit gaps, input bit bad_cs, input int abort_at);
    logic [7:0] cs = 8'd0;
    foreach (pkt[i]) cs ^= pkt[i];
    if (CS == 1 && pkt_n <= LIMIT) pkt.push_back(bad_cs ? ~cs : cs);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == abort_at) begin
        pulse_load_req(1'b1);
        return;
      end
      apply_stimulus(pkt[i], gaps);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed and random scenarios ----------------
  initial begin
    logic [WW-1:0] w0;
    int base_done;

    // Reset values while rstn is held low.
    @(negedge clk);
    check_output("rst_s_ready", 64'(s_ready), 64'd0);
    check_output("rst_ins_we", 64'(ins_we), 64'd0);
    check_output("rst_ins_waddr", 64'(ins_waddr), 64'd0);
    check_output("rst_ins_wdata", 64'(ins_wdata), 64'd0);
    check_output("rst_proc_rstn", 64'(proc_rstn), 64'd0);
    check_output("rst_load_done", 64'(load_done), 64'd0);
    check_output("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle(1);

    // Two-instruction program: ADD a=1,b=2,r=3 then SUB a=4,b=5,r=6.
    $display("[TB] two-instruction load");
    wr_log.delete();
    pkt_start(2);
    pkt_add_word({10'd1, 10'd2, 10'd3, 3'd0}, 1'b0);
    pkt_add_word({10'd4, 10'd5, 10'd6, 3'd1}, 1'b0);
    pkt_send(1'b0, 1'b0, -1);
    idle(2);
    check_output("add_sub_writes", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() >= 2) begin
      check_output("add_word", 64'(wr_log[0]), 64'({10'd0, 10'd1, 10'd2, 10'd3, 3'd0}));
      check_output("sub_word", 64'(wr_log[1]), 64'({10'd1, 10'd4, 10'd5, 10'd6, 3'd1}));
    end
    check_output("add_sub_done", 64'(done_count), 64'd1);
    check_output("add_sub_proc_rstn", 64'(proc_rstn), 64'd1);

    // Empty program.
    $display("[TB] empty load");
    pulse_load_req(1'b0);
    wr_log.delete();
    base_done = done_count;
    pkt_start(0);
    pkt_send(1'b0, 1'b0, -1);
    idle(2);
    check_output("empty_writes", 64'(wr_log.size()), 64'd0);
    check_output("empty_done", 64'(done_count), 64'(base_done + 1));
    check_output("empty_proc_rstn", 64'(proc_rstn), 64'd1);

    // Abort after three body bytes, with a byte colliding with load_req.
    $display("[TB] aborted load then reload");
    pulse_load_req(1'b0);
    pkt_start(1);
    pkt_add_word(rand_word(), 1'b1);
    pkt_send(1'b0, 1'b0, 5);
    wr_log.delete();
    w0 = rand_word();
    pkt_start(1);
    pkt_add_word(w0, 1'b1);
    pkt_send(1'b1, 1'b0, -1);
    idle(2);
    check_output("abort_writes", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() >= 1) check_output("abort_word", 64'(wr_log[0]), 64'({10'd0, w0}));

    // Randomised loads with gaps, junk high bits and occasional aborts.
    $display("[TB] random loads");
    for (int it = 0; it < 12; it++) begin
      int n, abort_at;
      pulse_load_req($urandom_range(0, 1) == 1);
      n = $urandom_range(1, 6);
      pkt_start(n);
      for (int j = 0; j < n; j++) pkt_add_word(rand_word(), 1'b1);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1 + NB * n) : -1;
      pkt_send(1'b1, 1'b0, abort_at);
      idle($urandom_range(1, 3));
    end

    // One-cycle reset in the middle of the body, then a clean load.
    $display("[TB] reset mid-body");
    pulse_load_req(1'b0);
    pkt_start(2);
    pkt_add_word(rand_word(), 1'b0);
    pkt_add_word(rand_word(), 1'b0);
    for (int i = 0; i < 2 + NB; i++) apply_stimulus(pkt[i], 1'b0);
    rstn    = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    @(negedge clk);
    check_output("midrst_s_ready", 64'(s_ready), 64'd0);
    check_output("midrst_ins_we", 64'(ins_we), 64'd0);
    check_output("midrst_ins_waddr", 64'(ins_waddr), 64'd0);
    check_output("midrst_ins_wdata", 64'(ins_wdata), 64'd0);
    check_output("midrst_proc_rstn", 64'(proc_rstn), 64'd0);
    check_output("midrst_err", 64'(err), 64'd0);
    rstn    = 1'b1;
    s_valid = 1'b0;
    idle(1);
    wr_log.delete();
    base_done = done_count;
    pkt_start(2);
    pkt_add_word(rand_word(), 1'b1);
    pkt_add_word(rand_word(), 1'b1);
    pkt_send(1'b0, 1'b0, -1);
    idle(2);
    check_output("postrst_writes", 64'(wr_log.size()), 64'd2);
    check_output("postrst_done", 64'(done_count), 64'(base_done + 1));

    // Count larger than instruction memory.
    $display("[TB] oversize load");
    pulse_load_req(1'b0);
    wr_log.delete();
    base_done = done_count;
    pkt_start(16'h0401);
    for (int j = 0; j < 16'h0401; j++) pkt_add_word(rand_word(), 1'b1);
    pkt_send(1'b0, 1'b0, -1);
    idle(2);
    check_output("ovf_write_count", 64'(wr_log.size()), 64'd1024);
    if (wr_log.size() >= 1) check_output("ovf_last_addr", 64'(wr_log[wr_log.size()-1] >> WW), 64'd1023);
    check_output("ovf_err", 64'(err), 64'd1);
    check_output("ovf_done", 64'(done_count), 64'(base_done));
    check_output("ovf_proc_rstn", 64'(proc_rstn), 64'd0);

`ifdef INS_LOADER_CHECKSUM_EN
    // Corrupted checksum byte.
    $display("[TB] bad checksum");
    pulse_load_req(1'b0);
    base_done = done_count;
    pkt_start(1);
    pkt_add_word(rand_word(), 1'b0);
    pkt_send(1'b0, 1'b1, -1);
    idle(2);
    check_output("cs_err", 64'(err), 64'd1);
    check_output("cs_proc_rstn", 64'(proc_rstn), 64'd0);
    check_output("cs_done", 64'(done_count), 64'(base_done));
    check_output("cs_s_ready", 64'(s_ready), 64'd1);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
